rvsteel_bus_arbiter: RTL and testbench
======================================

# rvsteel_bus_arbiter

Round-robin arbiter that shares the single manager port of `rvsteel_bus` between `NUM_MANAGERS` requesters, such as the `rvsteel_core` and a DMA engine. It sits between the managers and the bus manager interface. It serializes one transaction at a time and routes each response back to the granted requester. A timeout counter releases the bus when no device responds, so an unmapped access cannot stall the system.

## Interface
- `NUM_MANAGERS`, default 2: number of requesters, range 2–8.
- `TIMEOUT_CYCLES`, default 255: WAIT cycles allowed before forced completion, range 1–65535.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mgr_rw_address`  in  32*N  packed per-manager address.
- `mgr_write_data`  in  32*N  packed write data.
- `mgr_write_strobe`  in  4*N  packed byte strobes.
- `mgr_read_request`  in  N  level read request, held until response.
- `mgr_write_request`  in  N  level write request, held until response.
- `mgr_read_data`  out  32*N  read data; only the granted slot is valid.
- `mgr_read_response`  out  N  one-cycle read completion pulse.
- `mgr_write_response`  out  N  one-cycle write completion pulse.
- `bus_rw_address`, `bus_write_data`, `bus_write_strobe`  out  32/32/4  latched attributes of the granted transaction.
- `bus_read_request`, `bus_write_request`  out  1  one-cycle request pulse.
- `bus_read_data`  in  32;  `bus_read_response`, `bus_write_response`  in  1.
- `grant`  out  N  one-hot owner, valid in ISSUE and WAIT.
- `timeout_error`  out  1  one-cycle pulse on forced completion.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Pending set = `mgr_read_request | mgr_write_request`.
  - If non-empty, the winner is the first pending index after `last_grant`, searching modulo N.
  - On a winner: latch address, data, strobe and op; set `grant`; go to ISSUE.
- ISSUE:
  - Drive `bus_read_request` or `bus_write_request` high for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
  - A bus response arriving in ISSUE is accepted, handled as in WAIT.
- WAIT:
  - Wait for the bus response matching the latched op.
  - On response: combinationally pulse the winner's matching `mgr_*_response` and pass `bus_read_data` through to its `mgr_read_data` slot.
  - Then update `last_grant` to the winner and go to IDLE.
- Timeout: the counter increments each WAIT cycle. At count == `TIMEOUT_CYCLES - 1` with no response:
  - pulse the winner's response with read data 0;
  - pulse `timeout_error`;
  - go to IDLE.
- Op conflict: if a manager asserts both read and write in the grant cycle, write wins and the read is ignored.
- Attributes are latched at grant. Manager-side changes after grant are ignored.
- A manager dropping its request before the response does not abort the transaction. The bus transaction completes and the response pulse is still emitted.
- A non-matching bus response (read vs. write) is ignored.
- A response with no transaction outstanding (IDLE) is ignored.
- Reset (asynchronous, effective while `reset` = 0):
  - state IDLE, `last_grant` = N-1 (manager 0 has top priority);
  - all request, response, `grant` and `timeout_error` outputs 0;
  - `bus_*` attribute registers and `mgr_read_data` = 0.
- Reset mid-transaction abandons the transaction with no response. A late device response after reset is discarded as an IDLE response.

## Timing
- Request seen in IDLE at cycle t, then bus request pulsed at t+1.
- Fastest device (response at t+2): manager sees the response at t+2. Response-to-manager latency is 0 cycles (combinational).
- One IDLE cycle follows every completion, so the next grant is at t+3 at the earliest. Back-to-back throughput is one transaction per 3 cycles with zero-wait devices.
- Manager must deassert its request by the cycle after its response. Otherwise it is re-arbitrated as a new request.
- `grant` is registered. `bus_*` attributes are registered and stable from ISSUE through completion.
- Fairness: with all N requesters continuously pending, each is served within N transactions.

## Structure
- Shared package / header `rvsteel_bus_pkg`: FSM state encodings, address and data width constants (32), strobe width (4). The same constants are reused by `rvsteel_bus`.
- Sub-module `rvsteel_rr_picker`: combinational round-robin search.
  - inputs: pending N, `last_grant` index;
  - outputs: one-hot winner, `found`.
- Top module holds the FSM, the attribute latches, the timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`) and the response demux.

## Test plan
- Single read: manager 1 reads 0x8000_0000; device responds with 0xA5 two cycles later. Require:
  - `bus_read_request` one pulse at t+1;
  - `mgr_read_response[1]` pulse with 0x0000_00A5;
  - `grant` = 2'b10.
- Contention: both managers write every cycle with zero-wait RAM. Require:
  - grants alternate 0,1,0,1 starting from manager 0 after reset;
  - one transaction per 3 cycles;
  - strobes forwarded intact (e.g. 4'b0011).
- Timeout: `TIMEOUT_CYCLES` = 4, read with no device response. Require:
  - `timeout_error` and `mgr_read_response` pulse together on the 4th WAIT cycle;
  - read data 0;
  - the next pending manager is granted after one IDLE cycle.
- Conflict and late changes: manager 0 asserts read and write together. Require a write on the bus. Address changes after grant must not reach `bus_rw_address`.
- Reset mid-WAIT: assert `reset` low during WAIT, then release; the device responds after release. Require:
  - all outputs 0 immediately;
  - no manager response;
  - manager 0 has top priority afterwards.

Source files
------------

// File: rtl/rvsteel_bus_pkg.sv
// rtl/rvsteel_bus_pkg.sv - shared bus widths and arbiter state encodings
package rvsteel_bus_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rvsteel_rr_picker.sv
// rtl/rvsteel_rr_picker.sv - combinational round-robin search over pending requesters
//   pending    : one bit per requester
//   last_grant : index of the most recently served requester
//   winner     : one-hot choice, zero when nothing is pending
//   found      : high when winner is non-zero
module rvsteel_rr_picker
    import rvsteel_bus_pkg::*;
#(
    parameter int NUM_MANAGERS = 2,
    parameter int IDX_W        = $clog2(NUM_MANAGERS)
) (
    input  logic [NUM_MANAGERS-1:0] pending,
    input  logic [IDX_W-1:0]        last_grant,
    output logic [NUM_MANAGERS-1:0] winner,
    output logic                    found
);

    // Two passes emulate a modulo-N search starting just after last_grant:
    // first the indices above it, then wrap around to the indices up to it.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (!found && pending[i] && (i > int'(last_grant))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (!found && pending[i] && (i <= int'(last_grant))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvsteel_bus_arbiter.sv
// rtl/rvsteel_bus_arbiter.sv - round-robin arbiter sharing the rvsteel_bus manager port
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   mgr_*                 : packed per-requester request side, responses returned per slot
//   bus_*                 : single manager port toward rvsteel_bus
//   grant                 : one-hot owner during ISSUE and WAIT
//   timeout_error         : pulse when a transaction is force-completed
module rvsteel_bus_arbiter
    import rvsteel_bus_pkg::*;
#(
    parameter int NUM_MANAGERS   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clock,
    input  logic                               reset,

    input  logic [NUM_MANAGERS*ADDR_WIDTH-1:0] mgr_rw_address,
    input  logic [NUM_MANAGERS*DATA_WIDTH-1:0] mgr_write_data,
    input  logic [NUM_MANAGERS*STRB_WIDTH-1:0] mgr_write_strobe,
    input  logic [NUM_MANAGERS-1:0]            mgr_read_request,
    input  logic [NUM_MANAGERS-1:0]            mgr_write_request,
    output logic [NUM_MANAGERS*DATA_WIDTH-1:0] mgr_read_data,
    output logic [NUM_MANAGERS-1:0]            mgr_read_response,
    output logic [NUM_MANAGERS-1:0]            mgr_write_response,

    output logic [ADDR_WIDTH-1:0]              bus_rw_address,
    output logic [DATA_WIDTH-1:0]              bus_write_data,
    output logic [STRB_WIDTH-1:0]              bus_write_strobe,
    output logic                               bus_read_request,
    output logic                               bus_write_request,
    input  logic [DATA_WIDTH-1:0]              bus_read_data,
    input  logic                               bus_read_response,
    input  logic                               bus_write_response,

    output logic [NUM_MANAGERS-1:0]            grant,
    output logic                               timeout_error
);

    localparam int IDX_W = $clog2(NUM_MANAGERS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       last_grant;
    logic                   op_write;
    logic [CNT_W-1:0]       timeout_count;

    logic [NUM_MANAGERS-1:0] pending;
    logic [NUM_MANAGERS-1:0] winner;
    logic                    found;

    logic [ADDR_WIDTH-1:0]  sel_address;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [STRB_WIDTH-1:0]  sel_strobe;
    logic                   sel_write;
    logic [IDX_W-1:0]       grant_idx;

    logic                   in_flight;
    logic                   bus_match;
    logic                   timed_out;
    logic                   complete;

    assign pending = mgr_read_request | mgr_write_request;

    rvsteel_rr_picker #(
        .NUM_MANAGERS (NUM_MANAGERS),
        .IDX_W        (IDX_W)
    ) u_picker (
        .pending    (pending),
        .last_grant (last_grant),
        .winner     (winner),
        .found      (found)
    );

    // Attributes of the winning requester. A simultaneous read and write
    // request is treated as a write.
    always_comb begin
        sel_address = '0;
        sel_data    = '0;
        sel_strobe  = '0;
        sel_write   = 1'b0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (winner[i]) begin
                sel_address = mgr_rw_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data    = mgr_write_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strobe  = mgr_write_strobe[i*STRB_WIDTH +: STRB_WIDTH];
                sel_write   = mgr_write_request[i];
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Completion is combinational so the owner sees the bus response in the
    // same cycle; responses of the wrong kind or outside a transaction are
    // simply not matched.
    assign in_flight = (state == ARB_ISSUE) || (state == ARB_WAIT);
    assign bus_match = op_write ? bus_write_response : bus_read_response;
    assign timed_out = (state == ARB_WAIT) && !bus_match && (timeout_count == TIMEOUT_LAST);
    assign complete  = in_flight && (bus_match || timed_out);

    assign timeout_error      = timed_out;
    assign mgr_read_response  = (complete && !op_write) ? grant : '0;
    assign mgr_write_response = (complete &&  op_write) ? grant : '0;

    // Read data reaches only the owner's slot, and only with a real read
    // response; a forced completion returns zero.
    always_comb begin
        mgr_read_data = '0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (grant[i] && in_flight && !op_write && bus_read_response) begin
                mgr_read_data[i*DATA_WIDTH +: DATA_WIDTH] = bus_read_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= ARB_IDLE;
            last_grant        <= IDX_W'(NUM_MANAGERS - 1);
            grant             <= '0;
            op_write          <= 1'b0;
            timeout_count     <= '0;
            bus_rw_address    <= '0;
            bus_write_data    <= '0;
            bus_write_strobe  <= '0;
            bus_read_request  <= 1'b0;
            bus_write_request <= 1'b0;
        end else begin
            bus_read_request  <= 1'b0;
            bus_write_request <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        grant             <= winner;
                        op_write          <= sel_write;
                        bus_rw_address    <= sel_address;
                        bus_write_data    <= sel_data;
                        bus_write_strobe  <= sel_strobe;
                        bus_read_request  <= !sel_write;
                        bus_write_request <= sel_write;
                        state             <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    timeout_count <= '0;
                    if (complete) begin
                        last_grant <= grant_idx;
                        grant      <= '0;
                        state      <= ARB_IDLE;
                    end else begin
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (complete) begin
                        last_grant <= grant_idx;
                        grant      <= '0;
                        state      <= ARB_IDLE;
                    end else begin
                        timeout_count <= timeout_count + CNT_W'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// tb/tb_rvsteel_bus_arbiter.sv - scoreboard bench for rvsteel_bus_arbiter
module tb_rvsteel_bus_arbiter;

    localparam int N = 2;
    localparam int T = 4;
    localparam logic [31:0] UNMAPPED = 32'hDEAD_0000;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*32-1:0] mgr_rw_address;
    logic [N*32-1:0] mgr_write_data;
    logic [N*4-1:0]  mgr_write_strobe;
    logic [N-1:0]    mgr_read_request;
    logic [N-1:0]    mgr_write_request;
    logic [N*32-1:0] mgr_read_data;
    logic [N-1:0]    mgr_read_response;
    logic [N-1:0]    mgr_write_response;
    logic [31:0]     bus_rw_address;
    logic [31:0]     bus_write_data;
    logic [3:0]      bus_write_strobe;
    logic            bus_read_request;
    logic            bus_write_request;
    logic [31:0]     bus_read_data;
    logic            bus_read_response;
    logic            bus_write_response;
    logic [N-1:0]    grant;
    logic            timeout_error;

    rvsteel_bus_arbiter #(
        .NUM_MANAGERS   (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mgr_rw_address     (mgr_rw_address),
        .mgr_write_data     (mgr_write_data),
        .mgr_write_strobe   (mgr_write_strobe),
        .mgr_read_request   (mgr_read_request),
        .mgr_write_request  (mgr_write_request),
        .mgr_read_data      (mgr_read_data),
        .mgr_read_response  (mgr_read_response),
        .mgr_write_response (mgr_write_response),
        .bus_rw_address     (bus_rw_address),
        .bus_write_data     (bus_write_data),
        .bus_write_strobe   (bus_write_strobe),
        .bus_read_request   (bus_read_request),
        .bus_write_request  (bus_write_request),
        .bus_read_data      (bus_read_data),
        .bus_read_response  (bus_read_response),
        .bus_write_response (bus_write_response),
        .grant              (grant),
        .timeout_error      (timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          mgr;
        bit          wr;
        logic [31:0] rdata;
        bit          tmo;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          issue_q[$];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          tmo_cycle = -1;
    int          inject_req = 0;
    logic [31:0] dev_rdata = 32'h0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input int mgr, input bit wr, input logic [31:0] rdata, input bit tmo,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        exp_t e;
        e.mgr = mgr; e.wr = wr; e.rdata = rdata; e.tmo = tmo;
        e.addr = addr; e.wdata = wdata; e.strb = strb;
        exp_q.push_back(e);
    endtask

    // Device model: answers one cycle after the request pulse unless the
    // latched address is the unmapped one; inject_req forces a stray read reply.
    initial begin
        bit pend_rd, pend_wr, pend_map;
        int inject_seen;
        pend_rd = 0; pend_wr = 0; pend_map = 0; inject_seen = 0;
        bus_read_data = '0; bus_read_response = 1'b0; bus_write_response = 1'b0;
        forever begin
            @(posedge clock); #1;
            bus_read_response  = 1'b0;
            bus_write_response = 1'b0;
            bus_read_data      = '0;
            if (inject_req != inject_seen) begin
                bus_read_response = 1'b1;
                bus_read_data     = 32'h0000_0BAD;
                inject_seen       = inject_req;
            end else if (pend_rd && pend_map) begin
                bus_read_response = 1'b1;
                bus_read_data     = dev_rdata;
            end else if (pend_wr && pend_map) begin
                bus_write_response = 1'b1;
            end
            pend_rd  = bus_read_request;
            pend_wr  = bus_write_request;
            pend_map = (bus_rw_address != UNMAPPED);
        end
    end

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (bus_read_request || bus_write_request) issue_q.push_back(cycle);
        if ((|mgr_read_response) || (|mgr_write_response)) begin
            if (timeout_error) tmo_cycle = cycle;
            if (exp_q.size() == 0) begin
                check("unexpected_response", 64'({mgr_write_response, mgr_read_response}), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_read",  64'(mgr_read_response),  mon_e.wr ? 64'(0) : 64'(1) << mon_e.mgr);
                check("resp_write", 64'(mgr_write_response), mon_e.wr ? 64'(1) << mon_e.mgr : 64'(0));
                check("resp_grant", 64'(grant), 64'(1) << mon_e.mgr);
                check("resp_timeout_flag", 64'(timeout_error), 64'(mon_e.tmo));
                check("resp_bus_addr", 64'(bus_rw_address), 64'(mon_e.addr));
                if (mon_e.wr) begin
                    check("resp_bus_wdata", 64'(bus_write_data), 64'(mon_e.wdata));
                    check("resp_bus_strobe", 64'(bus_write_strobe), 64'(mon_e.strb));
                end else begin
                    check("resp_read_data", 64'(mgr_read_data[mon_e.mgr*32 +: 32]), 64'(mon_e.rdata));
                end
            end
        end else if (timeout_error) begin
            check("stray_timeout", 64'(timeout_error), 64'(0));
        end
    end

    task automatic mgr_txn(input int idx, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        bit got;
        got = 0;
        @(posedge clock); #1;
        mgr_rw_address[idx*32 +: 32]  = addr;
        mgr_write_data[idx*32 +: 32]  = wdata;
        mgr_write_strobe[idx*4 +: 4]  = strb;
        mgr_read_request[idx]         = rd;
        mgr_write_request[idx]        = wr;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clock);
            if (mgr_read_response[idx] || mgr_write_response[idx]) got = 1;
        end
        mgr_read_request[idx]  = 1'b0;
        mgr_write_request[idx] = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL txn_wait mgr%0d: no response within 30 cycles, expected one", idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, n0, n1;
        reset = 1'b0;
        mgr_rw_address = '0; mgr_write_data = '0; mgr_write_strobe = '0;
        mgr_read_request = '0; mgr_write_request = '0;
        repeat (2) @(negedge clock);
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_bus_req", 64'({bus_read_request, bus_write_request}), 64'(0));
        check("rst_bus_addr", 64'(bus_rw_address), 64'(0));
        check("rst_bus_strobe", 64'(bus_write_strobe), 64'(0));
        check("rst_mgr_rdata", mgr_read_data, 64'(0));
        check("rst_mgr_resp", 64'({mgr_read_response, mgr_write_response}), 64'(0));
        check("rst_timeout", 64'(timeout_error), 64'(0));
        @(posedge clock); #1;
        reset = 1'b1;

        // Single read by manager 1.
        dev_rdata = 32'h0000_00A5;
        push_exp(1, 0, 32'h0000_00A5, 0, 32'h8000_0000, 32'h0, 4'h0);
        @(posedge clock); #1;
        t0 = cycle;
        mgr_rw_address[63:32] = 32'h8000_0000;
        mgr_read_request[1]   = 1'b1;
        @(negedge clock);
        check("t1_no_req_in_idle", 64'(bus_read_request), 64'(0));
        @(negedge clock);
        check("t1_read_pulse", 64'(bus_read_request), 64'(1));
        check("t1_grant", 64'(grant), 64'(2'b10));
        check("t1_issue_latency", 64'(cycle - t0), 64'(1));
        @(negedge clock);
        check("t1_read_resp", 64'(mgr_read_response), 64'(2'b10));
        check("t1_read_pulse_gone", 64'(bus_read_request), 64'(0));
        mgr_read_request[1] = 1'b0;
        @(negedge clock);
        check("t1_resp_one_cycle", 64'(mgr_read_response), 64'(0));

        // Contention: both managers writing continuously.
        n0 = issue_q.size();
        push_exp(0, 1, 32'h0, 0, 32'h0000_1000, 32'h1111_1111, 4'b0011);
        push_exp(1, 1, 32'h0, 0, 32'h0000_2000, 32'h2222_2222, 4'b1100);
        push_exp(0, 1, 32'h0, 0, 32'h0000_1004, 32'h3333_3333, 4'b0011);
        push_exp(1, 1, 32'h0, 0, 32'h0000_2004, 32'h4444_4444, 4'b1100);
        fork
            begin
                mgr_txn(0, 0, 1, 32'h0000_1000, 32'h1111_1111, 4'b0011);
                mgr_txn(0, 0, 1, 32'h0000_1004, 32'h3333_3333, 4'b0011);
            end
            begin
                mgr_txn(1, 0, 1, 32'h0000_2000, 32'h2222_2222, 4'b1100);
                mgr_txn(1, 0, 1, 32'h0000_2004, 32'h4444_4444, 4'b1100);
            end
        join
        check("cont_issue_count", 64'(issue_q.size() - n0), 64'(4));
        if (issue_q.size() >= n0 + 4) begin
            for (int k = 0; k < 3; k++) begin
                check("cont_spacing", 64'(issue_q[n0+k+1] - issue_q[n0+k]), 64'(3));
            end
        end

        // Timeout: manager 0 reads unmapped space, manager 1 waits behind it.
        repeat (2) @(negedge clock);
        dev_rdata = 32'h1234_5678;
        n1 = issue_q.size();
        push_exp(0, 0, 32'h0, 1, UNMAPPED, 32'h0, 4'h0);
        push_exp(1, 0, 32'h1234_5678, 0, 32'h0000_3000, 32'h0, 4'h0);
        fork
            mgr_txn(0, 1, 0, UNMAPPED, 32'h0, 4'h0);
            mgr_txn(1, 1, 0, 32'h0000_3000, 32'h0, 4'h0);
        join
        check("tmo_issue_count", 64'(issue_q.size() - n1), 64'(2));
        if (issue_q.size() >= n1 + 2) begin
            check("tmo_after_issue", 64'(tmo_cycle - issue_q[n1]), 64'(4));
            check("tmo_next_grant", 64'(issue_q[n1+1] - tmo_cycle), 64'(2));
        end

        // Read+write conflict and attribute changes after grant.
        repeat (2) @(negedge clock);
        push_exp(0, 1, 32'h0, 0, 32'h0000_0040, 32'hCAFE_BABE, 4'b1111);
        @(posedge clock); #1;
        mgr_rw_address[31:0] = 32'h0000_0040;
        mgr_write_data[31:0] = 32'hCAFE_BABE;
        mgr_write_strobe[3:0] = 4'b1111;
        mgr_read_request[0]  = 1'b1;
        mgr_write_request[0] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("conf_write_pulse", 64'(bus_write_request), 64'(1));
        check("conf_no_read", 64'(bus_read_request), 64'(0));
        mgr_rw_address[31:0]  = 32'hFFFF_FFF0;
        mgr_write_data[31:0]  = 32'h0;
        mgr_write_strobe[3:0] = 4'h0;
        @(negedge clock);
        check("conf_write_resp", 64'(mgr_write_response), 64'(2'b01));
        mgr_read_request[0]  = 1'b0;
        mgr_write_request[0] = 1'b0;

        // Reset while waiting on an unmapped read from manager 1.
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        mgr_rw_address[63:32] = UNMAPPED;
        mgr_read_request[1]   = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rw_pre_grant", 64'(grant), 64'(2'b10));
        @(posedge clock); #1;
        reset = 1'b0;
        mgr_read_request[1] = 1'b0;
        #1;
        check("rw_grant", 64'(grant), 64'(0));
        check("rw_bus_req", 64'({bus_read_request, bus_write_request}), 64'(0));
        check("rw_bus_attr", {bus_rw_address, bus_write_data}, 64'(0));
        check("rw_bus_strobe", 64'(bus_write_strobe), 64'(0));
        check("rw_mgr_out", 64'({mgr_read_response, mgr_write_response, timeout_error}), 64'(0));
        check("rw_mgr_rdata", mgr_read_data, 64'(0));
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        inject_req++;
        repeat (3) @(negedge clock);
        push_exp(0, 1, 32'h0, 0, 32'h0000_0050, 32'h5555_5555, 4'b0001);
        push_exp(1, 1, 32'h0, 0, 32'h0000_0060, 32'h6666_6666, 4'b1000);
        fork
            mgr_txn(0, 0, 1, 32'h0000_0050, 32'h5555_5555, 4'b0001);
            mgr_txn(1, 0, 1, 32'h0000_0060, 32'h6666_6666, 4'b1000);
        join

        repeat (3) @(negedge clock);
        check("all_expected_seen", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
